// File: rtl/ro_meas_seq.sv
// ro_meas_seq -- measurement sequencer for the ring-oscillator bank.
//
// Selects an RO channel and clears the external ripple counter. It then
// enables the RO for WIN_LEN reference cycles and lets the counter settle
// for SETTLE cycles. Finally it samples the count onto a registered result
// bus. Runs on one channel (MODE=0) or sweeps channels 0..CH_SEL (MODE=1).
//
// Ports
//   CLK, RST        reference clock, asynchronous active-high reset
//   START, ABORT    1-cycle run request (IDLE only) / cancel current run
//   MODE            0 = single channel CH_SEL, 1 = sweep 0..CH_SEL
//   CH_SEL, WIN_LEN channel / last channel and window length, latched at START
//   RO_COUNT        ripple counter value from the bank
//   RO_EN, RO_SEL   registered enable and channel select to the RO bank
//   CNT_RSTN        active-low clear to the ripple counter
//   BUSY, DONE      run in progress / 1-cycle end-of-run pulse
//   RES_VALID       1-cycle pulse per measured channel, with RES_CH,
//                   RES_COUNT and RES_ERR (channel >= NCH, count forced to 0)
//
// Optional build macro RO_MEAS_MINMAX_EN adds MIN_COUNT/MIN_CH and
// MAX_COUNT/MAX_CH: the extremes over the non-error results of the last run.
module ro_meas_seq #(
  parameter int NCH    = 8,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16,
  parameter int SETTLE = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic             MODE,
  input  logic [SEL_W-1:0] CH_SEL,
  input  logic [WIN_W-1:0] WIN_LEN,
  input  logic [CNT_W-1:0] RO_COUNT,
  output logic             RO_EN,
  output logic [SEL_W-1:0] RO_SEL,
  output logic             CNT_RSTN,
  output logic             BUSY,
  output logic             DONE,
  output logic             RES_VALID,
  output logic [SEL_W-1:0] RES_CH,
  output logic [CNT_W-1:0] RES_COUNT,
  output logic             RES_ERR
`ifdef RO_MEAS_MINMAX_EN
  ,
  output logic [CNT_W-1:0] MIN_COUNT,
  output logic [SEL_W-1:0] MIN_CH,
  output logic [CNT_W-1:0] MAX_COUNT,
  output logic [SEL_W-1:0] MAX_CH
`endif
);

  // One down-counter times CLR, RUN and SETTLE, so it must hold the larger
  // of the window length and the settle count.
  localparam int SET_W = $clog2(SETTLE + 1);
  localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
  localparam logic [SEL_W:0] NCH_L = (SEL_W + 1)'(NCH);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_RUN, S_SETTLE, S_SAMPLE, S_NEXT, S_FIN
  } state_t;

  state_t             state_q, state_n;
  logic [TMR_W-1:0]   tmr_q, tmr_n;
  logic [SEL_W-1:0]   ptr_q, ptr_n;
  logic               mode_q;
  logic [SEL_W-1:0]   last_q;
  logic [WIN_W-1:0]   win_q;
  logic               accept, enter, sample, fin, ptr_oor;

  function automatic logic out_of_range(input logic [SEL_W-1:0] ch);
    return {1'b0, ch} >= NCH_L;
  endfunction

  assign accept  = (state_q == S_IDLE) && START && !ABORT;
  assign ptr_oor = out_of_range(ptr_q);

  // Run parameters are frozen at START, so register writes during a run
  // have no effect on it.
  always_ff @(posedge CLK) begin
    if (accept) begin
      mode_q <= MODE;
      last_q <= CH_SEL;
      win_q  <= WIN_LEN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_n;
      tmr_q   <= tmr_n;
      ptr_q   <= ptr_n;
    end
  end

  // tmr_q holds "remaining cycles - 1" in the timed states: leave on zero.
  always_comb begin
    state_n = state_q;
    tmr_n   = tmr_q;
    ptr_n   = ptr_q;
    enter   = 1'b0;
    sample  = 1'b0;
    fin     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          ptr_n = START && MODE ? '0 : CH_SEL;
          enter = 1'b1;
        end
      end
      S_CLR: begin
        if (tmr_q == '0) begin
          if (win_q == '0) begin
            state_n = S_SETTLE;
            tmr_n   = TMR_W'(SETTLE - 1);
          end else begin
            state_n = S_RUN;
            tmr_n   = TMR_W'(win_q) - 1'b1;
          end
        end else begin
          tmr_n = tmr_q - 1'b1;
        end
      end
      S_RUN: begin
        if (tmr_q == '0) begin
          state_n = S_SETTLE;
          tmr_n   = TMR_W'(SETTLE - 1);
        end else begin
          tmr_n = tmr_q - 1'b1;
        end
      end
      S_SETTLE: begin
        if (tmr_q == '0) state_n = S_SAMPLE;
        else             tmr_n   = tmr_q - 1'b1;
      end
      S_SAMPLE: begin
        sample  = 1'b1;
        state_n = mode_q ? S_NEXT : S_FIN;
      end
      S_NEXT: begin
        if (ptr_q == last_q) begin
          state_n = S_FIN;
        end else begin
          ptr_n = ptr_q + 1'b1;
          enter = 1'b1;
        end
      end
      S_FIN: begin
        fin     = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // Starting a channel: a non-existent channel never touches the bank and
    // goes straight to SAMPLE to report an error result.
    if (enter) begin
      if (out_of_range(ptr_n)) begin
        state_n = S_SAMPLE;
      end else begin
        state_n = S_CLR;
        tmr_n   = TMR_W'(1);
      end
    end

    if (ABORT && (state_q != S_IDLE)) begin
      state_n = S_IDLE;
      sample  = 1'b0;
      fin     = 1'b0;
    end
  end

  // All bank controls are decoded from the next state and registered, so
  // RO_EN is glitch-free and RO_SEL only moves on entry to CLR (RO_EN low).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RO_EN     <= 1'b0;
      RO_SEL    <= '0;
      CNT_RSTN  <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      RES_VALID <= 1'b0;
      RES_CH    <= '0;
      RES_COUNT <= '0;
      RES_ERR   <= 1'b0;
    end else begin
      RO_EN     <= (state_n == S_RUN);
      CNT_RSTN  <= (state_n != S_CLR);
      BUSY      <= (state_n != S_IDLE);
      DONE      <= fin;
      RES_VALID <= sample;
      if (state_n == S_CLR) RO_SEL <= ptr_n;
      if (sample) begin
        RES_CH    <= ptr_q;
        RES_COUNT <= ptr_oor ? '0 : RO_COUNT;
        RES_ERR   <= ptr_oor;
      end
    end
  end

`ifdef RO_MEAS_MINMAX_EN
  // Strict compares keep the earliest channel on ties.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      MIN_COUNT <= '0;
      MIN_CH    <= '0;
      MAX_COUNT <= '0;
      MAX_CH    <= '0;
    end else if (accept) begin
      MIN_COUNT <= '1;
      MIN_CH    <= '0;
      MAX_COUNT <= '0;
      MAX_CH    <= '0;
    end else if (sample && !ptr_oor) begin
      if (RO_COUNT < MIN_COUNT) begin
        MIN_COUNT <= RO_COUNT;
        MIN_CH    <= ptr_q;
      end
      if (RO_COUNT > MAX_COUNT) begin
        MAX_COUNT <= RO_COUNT;
        MAX_CH    <= ptr_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ro_meas_seq.sv
// tb_ro_meas_seq -- self-checking bench for ro_meas_seq.
// A behavioural RO bank model counts one tick every div_cfg[channel]
// enabled cycles and is cleared by CNT_RSTN. A table of runs gives the
// expected result timing, channels and counts. Hand-written sequences then
// cover ABORT, START while busy, START+ABORT in IDLE and reset mid-run.
// Build with +define+RO_MEAS_MINMAX_EN to also check the min/max outputs.
module tb_ro_meas_seq;

  localparam int NCH = 8, SEL_W = 4, CNT_W = 16, WIN_W = 16, SETTLE = 4;

  logic             clk = 1'b0;
  logic             RST, START, ABORT, MODE;
  logic [SEL_W-1:0] CH_SEL;
  logic [WIN_W-1:0] WIN_LEN;
  logic [CNT_W-1:0] ro_cnt;
  logic             RO_EN, CNT_RSTN, BUSY, DONE, RES_VALID, RES_ERR;
  logic [SEL_W-1:0] RO_SEL, RES_CH;
  logic [CNT_W-1:0] RES_COUNT;
`ifdef RO_MEAS_MINMAX_EN
  logic [CNT_W-1:0] MIN_COUNT, MAX_COUNT;
  logic [SEL_W-1:0] MIN_CH, MAX_CH;
`endif

  always #5 clk = ~clk;

  ro_meas_seq #(.NCH(NCH), .SEL_W(SEL_W), .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE(SETTLE)) dut (
    .CLK(clk), .RST(RST), .START(START), .ABORT(ABORT), .MODE(MODE),
    .CH_SEL(CH_SEL), .WIN_LEN(WIN_LEN), .RO_COUNT(ro_cnt),
    .RO_EN(RO_EN), .RO_SEL(RO_SEL), .CNT_RSTN(CNT_RSTN), .BUSY(BUSY), .DONE(DONE),
    .RES_VALID(RES_VALID), .RES_CH(RES_CH), .RES_COUNT(RES_COUNT), .RES_ERR(RES_ERR)
`ifdef RO_MEAS_MINMAX_EN
    , .MIN_COUNT(MIN_COUNT), .MIN_CH(MIN_CH), .MAX_COUNT(MAX_COUNT), .MAX_CH(MAX_CH)
`endif
  );

  // RO bank + ripple counter model.
  logic [7:0][7:0] div_cfg;
  logic [7:0]      div_cur;
  int              ph;
  assign div_cur = (RO_SEL < 4'd8) ? div_cfg[RO_SEL[2:0]] : 8'd1;
  always @(posedge clk) begin
    if (!CNT_RSTN) begin
      ro_cnt <= '0;
      ph     <= 0;
    end else if (RO_EN) begin
      if (ph + 1 >= int'(div_cur)) begin
        ro_cnt <= ro_cnt + 1'b1;
        ph     <= 0;
      end else begin
        ph <= ph + 1;
      end
    end
  end

  typedef struct packed {
    logic             mode;
    logic [SEL_W-1:0] ch;
    logic [WIN_W-1:0] win;
    logic [7:0][7:0]  div;
    int               nres;
    logic [7:0][15:0] cnt;
    logic             err;
    int               t_valid;  // edges after the START edge to first RES_VALID
    int               period;
    int               t_done;
    int               en_cyc;   // total RO_EN-high cycles
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];
  int   n_tests, n_fail;
  logic [SEL_W-1:0] last_ch;
  logic [CNT_W-1:0] last_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic m, input int ch, input int win, input int nres,
                         input int tv, input int per, input int td, input int en);
    vecs[i]         = '0;
    vecs[i].mode    = m;
    vecs[i].ch      = SEL_W'(ch);
    vecs[i].win     = WIN_W'(win);
    vecs[i].nres    = nres;
    vecs[i].err     = (ch >= NCH);
    vecs[i].t_valid = tv;
    vecs[i].period  = per;
    vecs[i].t_done  = td;
    vecs[i].en_cyc  = en;
    for (int c = 0; c < 8; c++) vecs[i].div[c] = 8'd1;
  endtask

  // inj: edge index after which a second START (different settings) is
  // pulsed while busy; -1 for none.
  task automatic run_vec(input int i, input int inj);
    vec_t v;
    int t, nv, en;
    logic done_seen, sel_ok;
    v = vecs[i];
    div_cfg = v.div;
    @(negedge clk);
    MODE = v.mode; CH_SEL = v.ch; WIN_LEN = v.win; START = 1'b1;
    @(posedge clk); #1;
    START = 1'b0;
    t = 0; nv = 0; en = 0; done_seen = 1'b0; sel_ok = 1'b1;
    while (!done_seen && t < 400) begin
      @(posedge clk); #1;
      t++;
      START = 1'b0;
      if (t == 1) chk($sformatf("v%0d_busy", i), 32'(BUSY), 32'd1);
      if (RO_EN) begin
        en++;
        if (RO_SEL !== (v.mode ? SEL_W'(nv) : v.ch)) sel_ok = 1'b0;
      end
      if (RES_VALID) begin
        chk($sformatf("v%0d_r%0d_time", i, nv), 32'(t), 32'(v.t_valid + nv * v.period));
        if (nv < 8) begin
          chk($sformatf("v%0d_r%0d_ch", i, nv), 32'(RES_CH), 32'(v.mode ? SEL_W'(nv) : v.ch));
          chk($sformatf("v%0d_r%0d_cnt", i, nv), 32'(RES_COUNT), 32'(v.cnt[nv]));
          chk($sformatf("v%0d_r%0d_err", i, nv), 32'(RES_ERR), 32'(v.err));
          last_ch  = v.mode ? SEL_W'(nv) : v.ch;
          last_cnt = v.cnt[nv];
        end
        nv++;
      end
      if (DONE) begin
        done_seen = 1'b1;
        chk($sformatf("v%0d_done_time", i), 32'(t), 32'(v.t_done));
        chk($sformatf("v%0d_busy_at_done", i), 32'(BUSY), 32'd0);
      end
      if (t == inj) begin
        START = 1'b1; MODE = ~v.mode; CH_SEL = 4'd1; WIN_LEN = 16'd3;
      end
    end
    chk($sformatf("v%0d_done_seen", i), 32'(done_seen), 32'd1);
    chk($sformatf("v%0d_nres", i), 32'(nv), 32'(v.nres));
    chk($sformatf("v%0d_ro_en_cycles", i), 32'(en), 32'(v.en_cyc));
    chk($sformatf("v%0d_ro_sel_in_run", i), 32'(sel_ok), 32'd1);
  endtask

  initial begin
    int nvld, ndone;
    n_tests = 0; n_fail = 0;
    RST = 1'b1; START = 1'b0; ABORT = 1'b0; MODE = 1'b0; CH_SEL = '0; WIN_LEN = '0;
    div_cfg = '1;

    // single ch2, W=10, ticks every 2 cycles: 5; valid at 3+W+SETTLE, done +1
    set_vec(0, 1'b0, 2, 10, 1, 17, 0, 18, 10);
    vecs[0].div[2] = 8'd2; vecs[0].cnt[0] = 16'd5;
    // sweep 0..5, W=8, channel c ticks every c+1: period W+SETTLE+4 = 16
    set_vec(1, 1'b1, 5, 8, 6, 15, 16, 97, 48);
    for (int c = 0; c < 6; c++) vecs[1].div[c] = 8'(c + 1);
    vecs[1].cnt[0] = 16'd8; vecs[1].cnt[1] = 16'd4; vecs[1].cnt[2] = 16'd2;
    vecs[1].cnt[3] = 16'd2; vecs[1].cnt[4] = 16'd1; vecs[1].cnt[5] = 16'd1;
    // channel 9 does not exist: straight to SAMPLE, error result, count 0
    set_vec(2, 1'b0, 9, 10, 1, 1, 0, 2, 0);
    // W=0: no RUN, cleared counter sampled, DONE at 4+SETTLE
    set_vec(3, 1'b0, 3, 0, 1, 7, 0, 8, 0);
    // sweep 0..1, W=5, dividers 1,2: counts 5,2, period 13
    set_vec(4, 1'b1, 1, 5, 2, 12, 13, 27, 10);
    vecs[4].div[1] = 8'd2; vecs[4].cnt[0] = 16'd5; vecs[4].cnt[1] = 16'd2;
    // sweep 0..3, W=63, dividers 9,21,7,21: counts 7,3,9,3
    set_vec(5, 1'b1, 3, 63, 4, 70, 71, 285, 252);
    vecs[5].div[0] = 8'd9; vecs[5].div[1] = 8'd21; vecs[5].div[2] = 8'd7; vecs[5].div[3] = 8'd21;
    vecs[5].cnt[0] = 16'd7; vecs[5].cnt[1] = 16'd3; vecs[5].cnt[2] = 16'd9; vecs[5].cnt[3] = 16'd3;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ro_en", 32'(RO_EN), 32'd0);
    chk("rst_cnt_rstn", 32'(CNT_RSTN), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_res_valid", 32'(RES_VALID), 32'd0);
    chk("rst_res_count", 32'(RES_COUNT), 32'd0);
    @(negedge clk); RST = 1'b0;
    @(posedge clk); #1;
    chk("cnt_rstn_after_rst", 32'(CNT_RSTN), 32'd1);
    chk("busy_after_rst", 32'(BUSY), 32'd0);

    for (int i = 0; i < NV; i++) run_vec(i, -1);
`ifdef RO_MEAS_MINMAX_EN
    chk("min_count", 32'(MIN_COUNT), 32'd3);
    chk("min_ch", 32'(MIN_CH), 32'd1);
    chk("max_count", 32'(MAX_COUNT), 32'd9);
    chk("max_ch", 32'(MAX_CH), 32'd2);
`endif

    // START while busy must leave the run exactly as vector 0.
    run_vec(0, 5);

    // ABORT in the third RUN cycle.
    div_cfg = vecs[0].div;
    @(negedge clk); MODE = 1'b0; CH_SEL = 4'd2; WIN_LEN = 16'd10; START = 1'b1;
    @(posedge clk); #1; START = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_pre_ro_en", 32'(RO_EN), 32'd1);
    ABORT = 1'b1;
    @(posedge clk); #1; ABORT = 1'b0;
    chk("abort_ro_en", 32'(RO_EN), 32'd0);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_cnt_rstn", 32'(CNT_RSTN), 32'd1);
    nvld = 0; ndone = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (RES_VALID) nvld++;
      if (DONE) ndone++;
    end
    chk("abort_no_valid", 32'(nvld), 32'd0);
    chk("abort_no_done", 32'(ndone), 32'd0);
    chk("abort_res_ch_held", 32'(RES_CH), 32'(last_ch));
    chk("abort_res_cnt_held", 32'(RES_COUNT), 32'(last_cnt));

    // START and ABORT together in IDLE: nothing starts.
    @(negedge clk); START = 1'b1; ABORT = 1'b1;
    @(posedge clk); #1; START = 1'b0; ABORT = 1'b0;
    chk("start_abort_busy", 32'(BUSY), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("start_abort_cnt_rstn", 32'(CNT_RSTN), 32'd1);

    // Reset pulsed mid-RUN clears outputs without a clock edge.
    @(negedge clk); MODE = 1'b0; CH_SEL = 4'd2; WIN_LEN = 16'd10; START = 1'b1;
    @(posedge clk); #1; START = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid_pre_ro_en", 32'(RO_EN), 32'd1);
    @(negedge clk); RST = 1'b1;
    #1;
    chk("rst_mid_ro_en", 32'(RO_EN), 32'd0);
    chk("rst_mid_ro_sel", 32'(RO_SEL), 32'd0);
    chk("rst_mid_busy", 32'(BUSY), 32'd0);
    chk("rst_mid_cnt_rstn", 32'(CNT_RSTN), 32'd0);
    chk("rst_mid_res_ch", 32'(RES_CH), 32'd0);
    chk("rst_mid_res_count", 32'(RES_COUNT), 32'd0);
    @(negedge clk); RST = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_cnt_rstn_back", 32'(CNT_RSTN), 32'd1);
    run_vec(0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
